// File: rtl/mpsoc_noc_pkg.sv
// Shared definitions for the buffered NoC demultiplexer: default header field
// positions, the demux state encoding and the class-to-channel mask lookup.
package mpsoc_noc_pkg;

   localparam int unsigned DEFAULT_FLIT_WIDTH = 32;
   localparam int unsigned DEFAULT_CLASS_MSB  = 26;
   localparam int unsigned DEFAULT_CLASS_LSB  = 24;

   // Widest mapping table and channel count the lookup helper supports.
   localparam int unsigned MAP_MAX_BITS = 1024;
   localparam int unsigned MAX_CHANNELS = 16;

   typedef enum logic [1:0] {
      StHeader,
      StBody,
      StDrop
   } demux_state_e;

   // Output mask for class cls; bits at and above channels are forced to zero.
   function automatic logic [MAX_CHANNELS-1:0] map_slice(input logic [MAP_MAX_BITS-1:0] mapping,
                                                          input int unsigned cls,
                                                          input int unsigned channels);
      logic [MAP_MAX_BITS-1:0] shifted;
      logic [MAX_CHANNELS-1:0] keep;
      shifted = mapping >> (cls * channels);
      keep    = {MAX_CHANNELS{1'b1}} >> (MAX_CHANNELS - channels);
      return shifted[MAX_CHANNELS-1:0] & keep;
   endfunction

endpackage

// File: rtl/mpsoc_noc_demux_fifo.sv
// Per-channel circular FIFO. Depth need not be a power of two; pointers wrap
// explicitly at DEPTH. Pushes into a full FIFO and pops from an empty one are ignored.
module mpsoc_noc_demux_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, wr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign do_push  = push && (cnt_q != CNT_W'(DEPTH));
   assign do_pop   = pop && (cnt_q != '0);
   assign data_out = mem_q[rd_q];
   assign count    = cnt_q;
   assign empty    = (cnt_q == '0);

   // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= next_ptr(wr_q);
         if (do_pop)  rd_q <= next_ptr(rd_q);
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
      end
   end

   // Storage array; contents are only meaningful where the count says so.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_in;
   end

endmodule

// File: rtl/mpsoc_noc_demux_buffered.sv
// Packet-level NoC demultiplexer with one small FIFO per output channel. The header
// flit's class field picks an output mask; the whole worm follows that mask and each
// flit is written to every target FIFO in the same cycle or not at all.
// Optional build macro MPSOC_NOC_DEMUX_DROP_EN: unmapped classes are dropped (and
// counted on drop_count) instead of falling back to channel 0.
module mpsoc_noc_demux_buffered
   import mpsoc_noc_pkg::*;
#(
   parameter int unsigned FLIT_WIDTH   = DEFAULT_FLIT_WIDTH,
   parameter int unsigned CHANNELS     = 7,
   parameter int unsigned CLASS_MSB    = DEFAULT_CLASS_MSB,
   parameter int unsigned CLASS_LSB    = DEFAULT_CLASS_LSB,
   parameter logic [(2**(CLASS_MSB-CLASS_LSB+1))*CHANNELS-1:0] MAPPING = '0,
   parameter int unsigned BUFFER_DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [FLIT_WIDTH-1:0]                in_flit,
   input  logic                                 in_last,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
   output logic [CHANNELS-1:0]                  out_last,
   output logic [CHANNELS-1:0]                  out_valid,
   input  logic [CHANNELS-1:0]                  out_ready
`ifdef MPSOC_NOC_DEMUX_DROP_EN
   ,
   output logic [15:0]                          drop_count
`endif
);

   localparam int unsigned CLASS_W = CLASS_MSB - CLASS_LSB + 1;
   localparam int unsigned CNT_W   = $clog2(BUFFER_DEPTH + 1);

   logic [CHANNELS-1:0]     active_q, active_d;
   logic [CLASS_W-1:0]      hdr_class;
   logic [MAX_CHANNELS-1:0] map_raw;
   logic [CHANNELS-1:0]     sel_raw, sel, target, not_full, push;
   logic [CNT_W-1:0]        count [CHANNELS];
   logic [CHANNELS-1:0]     empty;
   logic                    accept;
   demux_state_e            state;

`ifdef MPSOC_NOC_DEMUX_DROP_EN
   logic        drop_q, drop_d;
   logic [15:0] drop_count_q, drop_count_d;
   assign drop_count = drop_count_q;
`endif

   assign hdr_class = in_flit[CLASS_MSB:CLASS_LSB];
   assign map_raw   = map_slice(MAP_MAX_BITS'(MAPPING), 32'(hdr_class), CHANNELS);
   assign sel_raw   = map_raw[CHANNELS-1:0];

`ifdef MPSOC_NOC_DEMUX_DROP_EN
   assign sel = sel_raw;
`else
   // Unmapped classes land on channel 0 so no packet is ever lost.
   assign sel = (sel_raw == '0) ? CHANNELS'(1) : sel_raw;
`endif

   // Decode the routing state from the registered route mask (and drop flag).
   always_comb begin
      state = StHeader;
`ifdef MPSOC_NOC_DEMUX_DROP_EN
      if (drop_q) state = StDrop;
      else
`endif
      if (active_q != '0) state = StBody;
   end

   // Target mask: class lookup on headers, held route on body flits, none while dropping.
   always_comb begin
      target = '0;
      unique case (state)
         StHeader: target = sel;
         StBody:   target = active_q;
         default:  target = '0;
      endcase
   end

   // Ready only from registered counts, so a same-cycle pop never frees a full FIFO.
   assign in_ready = ((target & ~not_full) == '0);
   assign accept   = in_valid && in_ready;
   assign push     = accept ? target : '0;

   // Route and drop bookkeeping for the next flit.
   always_comb begin
      active_d = active_q;
`ifdef MPSOC_NOC_DEMUX_DROP_EN
      drop_d       = drop_q;
      drop_count_d = drop_count_q;
`endif
      if (accept) begin
         unique case (state)
            StHeader: begin
               if (!in_last) active_d = sel;
`ifdef MPSOC_NOC_DEMUX_DROP_EN
               if (sel == '0) begin
                  drop_d = !in_last;
                  if (drop_count_q != 16'hffff) drop_count_d = drop_count_q + 16'd1;
               end
`endif
            end
            StBody: begin
               if (in_last) active_d = '0;
            end
            default: begin
`ifdef MPSOC_NOC_DEMUX_DROP_EN
               if (in_last) drop_d = 1'b0;
`endif
            end
         endcase
      end
   end

   // Route state registers; reset abandons any partially routed packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= '0;
`ifdef MPSOC_NOC_DEMUX_DROP_EN
         drop_q       <= 1'b0;
         drop_count_q <= '0;
`endif
      end else begin
         active_q <= active_d;
`ifdef MPSOC_NOC_DEMUX_DROP_EN
         drop_q       <= drop_d;
         drop_count_q <= drop_count_d;
`endif
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_fifo
      logic [FLIT_WIDTH:0] head;

      mpsoc_noc_demux_fifo #(
         .WIDTH(FLIT_WIDTH + 1),
         .DEPTH(BUFFER_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push    (push[i]),
         .data_in ({in_last, in_flit}),
         .pop     (out_ready[i]),
         .data_out(head),
         .count   (count[i]),
         .empty   (empty[i])
      );

      assign out_flit[i]  = head[FLIT_WIDTH-1:0];
      assign out_last[i]  = head[FLIT_WIDTH];
      assign out_valid[i] = ~empty[i];
      assign not_full[i]  = (count[i] < CNT_W'(BUFFER_DEPTH));
   end

endmodule
